// File: rtl/gate_access_sched.sv
// gate_access_sched
//   Scheduler for one shared parking gate fed by two PIN keypads.
//   Requests are arbitrated round-robin. The winning keypad's PIN is checked
//   against the stored password. The gate opens on a match and closes when a
//   vehicle passes or the open timer expires. Wrong PINs are counted per
//   keypad. Reaching MAX_TRIES, or a tailgating event, locks the gate out for
//   LOCK_CYC cycles.
//
//   Compile-time option:
//     STICKY_ALARM_EN  When defined, wrong_pin_alarm latches on any mismatch.
//                      It clears on the next correct PIN (from either keypad),
//                      when a lockout ends, or on reset. When undefined, it is
//                      a one-cycle pulse on each mismatch.
//
//   Ports:
//     clk              system clock, rising edge
//     rst              asynchronous active-low reset
//     req[1:0]         per-keypad request level, held until ack
//     pin0, pin1       keypad PINs, stable while the matching req bit is high
//     rghtpss          correct password
//     s01              vehicle-present sensor at the gate
//     s02              vehicle-passed sensor beyond the gate
//     grant[1:0]       one-hot gate owner, 0 when free
//     ack[1:0]         one-cycle pulse to the owner when its PIN check completes
//     pin_ok           qualifies ack: 1 = PIN matched
//     gate             1 = gate open
//     wrong_pin_alarm  wrong-PIN indication
//     lock_alarm       lockout / tailgating alarm
//   All outputs are registered.

module gate_access_sched #(
  parameter int PIN_W     = 16,
  parameter int MAX_TRIES = 3,
  parameter int OPEN_CYC  = 8,
  parameter int LOCK_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [PIN_W-1:0] pin0,
  input  logic [PIN_W-1:0] pin1,
  input  logic [PIN_W-1:0] rghtpss,
  input  logic             s01,
  input  logic             s02,
  output logic [1:0]       grant,
  output logic [1:0]       ack,
  output logic             pin_ok,
  output logic             gate,
  output logic             wrong_pin_alarm,
  output logic             lock_alarm
);

`ifdef STICKY_ALARM_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam int TRW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int TW  = (OPEN_CYC  > 1) ? $clog2(OPEN_CYC)      : 1;
  localparam int LW  = (LOCK_CYC  > 1) ? $clog2(LOCK_CYC)      : 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    OPEN,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ack_q, ack_d;
  logic             pin_ok_q, pin_ok_d;
  logic             gate_q, gate_d;
  logic             wpa_q, wpa_d;
  logic             lock_q, lock_d;
  logic             owner_q, owner_d;     // index of the current gate owner
  logic             rr_q, rr_d;           // keypad preferred when both request
  logic             tail_q, tail_d;       // current lockout came from tailgating
  logic [TRW-1:0]   try0_q, try0_d;
  logic [TRW-1:0]   try1_q, try1_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;

  // Shared decode used by both combinational processes
  logic             pick;
  logic [PIN_W-1:0] sel_pin;
  logic             pin_match;
  logic [TRW-1:0]   try_cur;
  logic [TRW-1:0]   try_inc;
  logic             hit_max;
  logic             timer_done;
  logic             lock_done;

  // Single request: that keypad wins. Both: the round-robin pointer decides.
  assign pick       = (req == 2'b11) ? rr_q : req[1];
  assign sel_pin    = owner_q ? pin1 : pin0;
  assign pin_match  = (sel_pin == rghtpss);
  assign try_cur    = owner_q ? try1_q : try0_q;
  assign try_inc    = (try_cur == TRW'(MAX_TRIES)) ? try_cur : try_cur + TRW'(1);
  assign hit_max    = (try_inc == TRW'(MAX_TRIES));
  assign timer_done = (timer_q == TW'(OPEN_CYC - 1));
  assign lock_done  = (lcnt_q == LW'(LOCK_CYC - 1));

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      pin_ok_q <= 1'b0;
      gate_q  <= 1'b0;
      wpa_q   <= 1'b0;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      tail_q  <= 1'b0;
      try0_q  <= '0;
      try1_q  <= '0;
      timer_q <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      pin_ok_q <= pin_ok_d;
      gate_q  <= gate_d;
      wpa_q   <= wpa_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      tail_q  <= tail_d;
      try0_q  <= try0_d;
      try1_q  <= try1_d;
      timer_q <= timer_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) state_d = CHECK;
      end
      CHECK: begin
        if (pin_match)    state_d = OPEN;
        else if (hit_max) state_d = LOCKED;
        else              state_d = IDLE;
      end
      OPEN: begin
        if (s01 && s02)              state_d = LOCKED;
        else if (s02)                state_d = IDLE;
        else if (!s01 && timer_done) state_d = IDLE;
      end
      LOCKED: begin
        if (lock_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output and datapath next values
  always_comb begin
    grant_d  = grant_q;
    ack_d    = '0;
    pin_ok_d = 1'b0;
    gate_d   = gate_q;
    wpa_d    = STICKY ? wpa_q : 1'b0;
    lock_d   = lock_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    tail_d   = tail_q;
    try0_d   = try0_q;
    try1_d   = try1_q;
    timer_d  = timer_q;
    lcnt_d   = lcnt_q;

    unique case (state_q)
      IDLE: begin
        gate_d  = 1'b0;
        lock_d  = 1'b0;
        grant_d = '0;
        if (req != 2'b00) begin
          owner_d = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          rr_d    = ~pick;
        end
      end

      CHECK: begin
        ack_d   = grant_q;
        timer_d = '0;
        lcnt_d  = '0;
        if (pin_match) begin
          pin_ok_d = 1'b1;
          gate_d   = 1'b1;
          wpa_d    = 1'b0;
          if (owner_q) try1_d = '0;
          else         try0_d = '0;
        end else begin
          wpa_d   = 1'b1;
          grant_d = '0;
          if (owner_q) try1_d = try_inc;
          else         try0_d = try_inc;
          if (hit_max) begin
            lock_d = 1'b1;
            tail_d = 1'b0;
          end
        end
      end

      OPEN: begin
        // Priority matters: tailgating beats a clean pass, which beats timeout.
        if (s01 && s02) begin
          gate_d  = 1'b0;
          grant_d = '0;
          lock_d  = 1'b1;
          tail_d  = 1'b1;
          lcnt_d  = '0;
        end else if (s02) begin
          gate_d  = 1'b0;
          grant_d = '0;
        end else if (s01) begin
          timer_d = '0;
        end else if (timer_done) begin
          gate_d  = 1'b0;
          grant_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      LOCKED: begin
        gate_d  = 1'b0;
        grant_d = '0;
        if (lock_done) begin
          lock_d = 1'b0;
          wpa_d  = 1'b0;
          // A tailgating lockout leaves both try counters untouched.
          if (!tail_q) begin
            if (owner_q) try1_d = '0;
            else         try0_d = '0;
          end
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end

      default: begin
        gate_d  = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  assign grant           = grant_q;
  assign ack             = ack_q;
  assign pin_ok          = pin_ok_q;
  assign gate            = gate_q;
  assign wrong_pin_alarm = wpa_q;
  assign lock_alarm      = lock_q;

endmodule

// File: tb/tb_gate_access_sched.sv
`timescale 1ns/1ps
module tb_gate_access_sched;

  localparam logic [15:0] PASS = 16'h4037;
`ifdef STICKY_ALARM_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] pin0, pin1, rghtpss;
  logic        s01, s02;
  logic [1:0]  grant, ack;
  logic        pin_ok, gate, wrong_pin_alarm, lock_alarm;

  gate_access_sched #(
    .PIN_W(16), .MAX_TRIES(3), .OPEN_CYC(8), .LOCK_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .pin0(pin0), .pin1(pin1),
    .rghtpss(rghtpss), .s01(s01), .s02(s02), .grant(grant), .ack(ack),
    .pin_ok(pin_ok), .gate(gate), .wrong_pin_alarm(wrong_pin_alarm),
    .lock_alarm(lock_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ack;
    logic       ok;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] a, input logic ok);
    exp_t e;
    e.ack = a;
    e.ok  = ok;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 12; i++) begin
      step();
      if (grant != 2'b00) break;
    end
    chk({tag, "_grant"}, {30'd0, grant}, {30'd0, exp});
  endtask

  task automatic wait_ack(input string tag);
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack != 2'b00) break;
    end
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.ack = 2'b11;
      e.ok  = 1'b1;
    end
    chk({tag, "_ack"}, {30'd0, ack}, {30'd0, e.ack});
    chk({tag, "_pin_ok"}, {31'd0, pin_ok}, {31'd0, e.ok});
  endtask

  task automatic vehicle_pass(input string tag);
    s01 = 1'b1;
    step();
    chk({tag, "_gate_held"}, {31'd0, gate}, 32'd1);
    s01 = 1'b0;
    s02 = 1'b1;
    step();
    chk({tag, "_gate_closed"}, {31'd0, gate}, 32'd0);
    chk({tag, "_grant_free"}, {30'd0, grant}, 32'd0);
    s02 = 1'b0;
  endtask

  // Wrong-PIN attempt from keypad k; exp_lock says whether it must lock out.
  task automatic attempt(input string tag, input logic k, input logic exp_lock);
    logic [1:0] oh;
    oh = k ? 2'b10 : 2'b01;
    req = oh;
    push_exp(oh, 1'b0);
    wait_grant(tag, oh);
    wait_ack(tag);
    req = 2'b00;
    chk({tag, "_lock"}, {31'd0, lock_alarm}, {31'd0, exp_lock});
    if (!exp_lock) begin
      chk({tag, "_wpa"}, {31'd0, wrong_pin_alarm}, 32'd1);
      step();
      chk({tag, "_wpa_after"}, {31'd0, wrong_pin_alarm}, {31'd0, STICKY});
    end
  endtask

  // Count cycles lock_alarm stays high, starting from a sample where it is 1.
  task automatic lock_len(input string tag, output logic saw_grant);
    int n;
    n = 1;
    saw_grant = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (grant != 2'b00) saw_grant = 1'b1;
      if (lock_alarm == 1'b0) break;
      n++;
    end
    chk({tag, "_lock_len"}, n, 32'd16);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic sg;
    int   n;
    rst = 1'b0; req = 2'b00; pin0 = '0; pin1 = '0; rghtpss = PASS;
    s01 = 1'b0; s02 = 1'b0;
    step();
    step();
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_gate", {31'd0, gate}, 32'd0);
    chk("rst_wpa", {31'd0, wrong_pin_alarm}, 32'd0);
    chk("rst_lock", {31'd0, lock_alarm}, 32'd0);
    chk("rst_pin_ok", {31'd0, pin_ok}, 32'd0);
    rst = 1'b1;
    step();

    // Single correct request and vehicle pass
    pin0 = PASS;
    req = 2'b01;
    push_exp(2'b01, 1'b1);
    step();
    chk("t1_grant_lat", {30'd0, grant}, 32'd1);
    chk("t1_gate_pre", {31'd0, gate}, 32'd0);
    wait_ack("t1");
    chk("t1_gate", {31'd0, gate}, 32'd1);
    req = 2'b00;
    vehicle_pass("t1");

    // Round robin with both keypads requesting continuously
    do_reset();
    pin0 = PASS;
    pin1 = PASS;
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      logic [1:0] oh;
      oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      push_exp(oh, 1'b1);
      wait_grant("t2_rr", oh);
      wait_ack("t2");
      vehicle_pass("t2");
    end
    req = 2'b00;

    // Per-keypad try counters and wrong-PIN lockout
    pin0 = 16'h1111;
    pin1 = 16'h0000;
    attempt("t3_a1", 1'b1, 1'b0);
    attempt("t3_a2", 1'b1, 1'b0);
    attempt("t3_k0", 1'b0, 1'b0);
    attempt("t3_a3", 1'b1, 1'b1);
    pin1 = PASS;
    req = 2'b10;
    push_exp(2'b10, 1'b1);
    lock_len("t3", sg);
    chk("t3_req_ignored", {31'd0, sg}, 32'd0);
    wait_grant("t3_after", 2'b10);
    wait_ack("t3_after");
    chk("t3_gate", {31'd0, gate}, 32'd1);
    req = 2'b00;

    // Auto-close after OPEN_CYC idle cycles
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gate == 1'b0) break;
      n++;
    end
    chk("t4_open_len", n, 32'd8);
    chk("t4_lock", {31'd0, lock_alarm}, 32'd0);
    chk("t4_wpa", {31'd0, wrong_pin_alarm}, 32'd0);
    chk("t4_grant", {30'd0, grant}, 32'd0);

    // Tailgating lockout; keypad 0 counter (1 failure) must survive it
    req = 2'b10;
    push_exp(2'b10, 1'b1);
    wait_grant("t5", 2'b10);
    wait_ack("t5");
    req = 2'b00;
    s01 = 1'b1;
    s02 = 1'b1;
    step();
    s01 = 1'b0;
    s02 = 1'b0;
    chk("t5_gate", {31'd0, gate}, 32'd0);
    chk("t5_lock", {31'd0, lock_alarm}, 32'd1);
    chk("t5_grant", {30'd0, grant}, 32'd0);
    lock_len("t5", sg);
    attempt("t5_k0a", 1'b0, 1'b0);
    attempt("t5_k0b", 1'b0, 1'b1);
    lock_len("t5b", sg);

    // Asynchronous reset while the gate is open clears counters
    attempt("t6_k0a", 1'b0, 1'b0);
    attempt("t6_k0b", 1'b0, 1'b0);
    req = 2'b10;
    push_exp(2'b10, 1'b1);
    wait_grant("t6", 2'b10);
    wait_ack("t6");
    req = 2'b00;
    chk("t6_gate_open", {31'd0, gate}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_async_gate", {31'd0, gate}, 32'd0);
    chk("t6_async_grant", {30'd0, grant}, 32'd0);
    chk("t6_async_lock", {31'd0, lock_alarm}, 32'd0);
    step();
    rst = 1'b1;
    attempt("t6_k0c", 1'b0, 1'b0);
    req = 2'b10;
    push_exp(2'b10, 1'b1);
    wait_grant("t6_ok", 2'b10);
    wait_ack("t6_ok");
    req = 2'b00;
    chk("t6_wpa_clear", {31'd0, wrong_pin_alarm}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_access_sched.md
Name: gate_access_sched

Overview:
- Scheduler for one shared parking gate used by two PIN keypads (requester 0 and requester 1).
- Arbitrates keypad requests round-robin and checks the granted keypad's PIN against the stored password.
- Drives the gate open/close sequence from the vehicle sensors.
- Raises the wrong-PIN and lock alarms, keeping a separate failed-attempt count per keypad.

Parameters:
- PIN_W, 16: PIN and password width.
- MAX_TRIES, 3: consecutive wrong PINs from one keypad that trigger lockout.
- OPEN_CYC, 8: cycles the gate stays open with no vehicle before auto-close.
- LOCK_CYC, 16: lockout duration in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  2  request per keypad, level; held until ack.
- pin0  in  PIN_W  keypad 0 PIN; stable while req[0]=1.
- pin1  in  PIN_W  keypad 1 PIN; stable while req[1]=1.
- rghtpss  in  PIN_W  correct password.
- s01  in  1  vehicle-present sensor at the gate.
- s02  in  1  vehicle-passed sensor beyond the gate.
- grant  out  2  one-hot owner of the gate; 0 when free.
- ack  out  2  1-cycle pulse to the granted keypad when its PIN check completes.
- pin_ok  out  1  valid with ack: 1 = correct PIN.
- gate  out  1  1 = gate open.
- wrong_pin_alarm  out  1  wrong-PIN indication.
- lock_alarm  out  1  lockout or tailgating alarm.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Both try counters 0. RR pointer selects keypad 0 first.
- All outputs are registered.
- States: IDLE, CHECK, OPEN, LOCKED.
- IDLE:
  - If req != 0, grant one keypad and go to CHECK next cycle.
  - Single request: that keypad wins.
  - Both requesting: the keypad not granted last wins. The RR pointer flips after every grant.
- CHECK (1 cycle): compare the granted keypad's PIN with rghtpss.
  - Match: ack and pin_ok=1. Clear that keypad's try counter. gate=1. Go to OPEN.
  - Mismatch: ack, pin_ok=0, wrong_pin_alarm=1 for 1 cycle. Increment that keypad's try counter.
    - Counter reaches MAX_TRIES: go to LOCKED.
    - Otherwise: go to IDLE with grant cleared.
  - Req dropped before CHECK: the compare still runs and ack still pulses.
- OPEN (gate=1, grant held):
  - Timer counts while s01=0 and reloads while s01=1.
  - s02=1 and s01=0: close the gate and go to IDLE next cycle (vehicle passed).
  - s01=1 and s02=1 in the same cycle: tailgating. Close the gate, lock_alarm=1, go to LOCKED.
  - Timer reaches OPEN_CYC-1 with no vehicle: close and go to IDLE.
- LOCKED:
  - gate=0, grant=0, lock_alarm=1 for exactly LOCK_CYC cycles; requests are ignored.
  - Then clear the offending keypad's try counter and go to IDLE.
  - Tailgate lockout leaves both counters unchanged.
- Try counters:
  - Saturating, width clog2(MAX_TRIES+1).
  - Per keypad, so one keypad's failures never lock the other before the lockout.
- Reset mid-operation: immediate return to the reset values, including gate=0.
- Latency:
  - req to grant: 1 cycle.
  - grant to ack/gate: 1 cycle.
  - s02 to gate=0: 1 cycle.

Optional Feature:
- Macro: STICKY_ALARM_EN.
- Defined: wrong_pin_alarm sets on any mismatch and stays 1 until the next correct PIN from any keypad, a lockout ending, or reset.
- Undefined: wrong_pin_alarm is the 1-cycle pulse described in Behaviour.

Test Plan:
- rghtpss=16'h4037, req=2'b01, pin0=16'h4037 -> grant=01 next cycle; then ack=01, pin_ok=1, gate=1. s01=1 then s02=1 with s01=0 -> gate=0 one cycle later, grant=00.
- req=2'b11, both PINs correct, vehicle passes each time -> grant order 01 then 10 then 01 (round-robin).
- pin1=16'h0000 submitted 3 times -> wrong_pin_alarm pulses on the first and second attempts. The third attempt enters LOCKED: lock_alarm=1 for 16 cycles, req ignored. After that, a correct pin1 opens the gate.
- Correct PIN, gate open, s01=s02=0 for 8 cycles -> gate=0 with no alarm.
- Gate open, s01=1 and s02=1 in the same cycle -> gate=0, lock_alarm=1 for 16 cycles.
- Gate open, rst pulsed low mid-cycle -> gate, grant and lock_alarm go to 0 immediately; counters cleared. With STICKY_ALARM_EN defined, one wrong PIN holds wrong_pin_alarm=1 until a correct PIN is accepted.
